store_seq_checker: RTL and testbench

- Synthesizable checker that monitors the CPU data-memory write port and compares it against a programmed table of DEPTH expected (address, data) stores, in order.
- A cycle budget bounds the run; the block reports pass, fail and a fail cause.
- Sits beside the CPU/memory interconnect in top and replaces the single-store, bench-only pass/fail check with a reusable multi-store, timeout-bounded checker.

---
 rtl/store_seq_checker.sv | 181 ++++++++++++++++++
 tb/tb_store_seq_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_seq_checker.sv
// rtl/store_seq_checker.sv - in-order store sequence checker with cycle budget (optional capture: STORE_SEQ_CHECKER_CAPTURE_EN)
module store_seq_checker #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    parameter int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [IDX_W:0]    match_cnt,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [1:0]       FC_NONE    = 2'b00;
    localparam logic [1:0]       FC_ADDR    = 2'b01;
    localparam logic [1:0]       FC_DATA    = 2'b10;
    localparam logic [1:0]       FC_TIMEOUT = 2'b11;
    localparam logic [IDX_W:0]   LAST_IDX   = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0]   ALL_DONE   = (IDX_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t            state, state_n;
    logic [1:0]        fail_code_n;
    logic [IDX_W:0]    match_cnt_n;
    logic [CNT_W-1:0]  cycle_cnt_n;

    logic [ADDR_W-1:0] tbl_a [DEPTH];
    logic [DATA_W-1:0] tbl_d [DEPTH];
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              tbl_wr_ok;

`ifdef STORE_SEQ_CHECKER_CAPTURE_EN
    logic              cap_set;
    logic              cap_clr;
    logic [ADDR_W-1:0] err_addr_q;
    logic [DATA_W-1:0] err_data_q;
`endif

    // Table write is blocked while a run is in progress and for out-of-range indices
    assign tbl_wr_ok = tbl_we && (state != ST_RUN) && (32'(tbl_idx) < DEPTH);
    assign exp_addr  = tbl_a[match_cnt[IDX_W-1:0]];
    assign exp_data  = tbl_d[match_cnt[IDX_W-1:0]];

    // Expected-store table; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (tbl_wr_ok) begin
            tbl_a[tbl_idx] <= tbl_addr;
            tbl_d[tbl_idx] <= tbl_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next progress values; mismatches outrank pass, pass outranks timeout
    always_comb begin
        state_n     = state;
        fail_code_n = fail_code;
        match_cnt_n = match_cnt;
        cycle_cnt_n = cycle_cnt;
`ifdef STORE_SEQ_CHECKER_CAPTURE_EN
        cap_set     = 1'b0;
        cap_clr     = 1'b0;
`endif
        case (state)
            ST_RUN: begin
                if (w_en && (addr != exp_addr)) begin
                    state_n     = ST_FAIL;
                    fail_code_n = FC_ADDR;
`ifdef STORE_SEQ_CHECKER_CAPTURE_EN
                    cap_set     = 1'b1;
`endif
                end else if (w_en && (wdata != exp_data)) begin
                    state_n     = ST_FAIL;
                    fail_code_n = FC_DATA;
`ifdef STORE_SEQ_CHECKER_CAPTURE_EN
                    cap_set     = 1'b1;
`endif
                end else if (w_en && (match_cnt == LAST_IDX)) begin
                    state_n     = ST_PASS;
                    match_cnt_n = ALL_DONE;
                end else begin
                    if (w_en) begin
                        match_cnt_n = match_cnt + 1'b1;
                    end
                    if (cycle_cnt == CNT_LIMIT) begin
                        state_n     = ST_FAIL;
                        fail_code_n = FC_TIMEOUT;
                    end else if (cycle_cnt != CNT_MAX) begin
                        cycle_cnt_n = cycle_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_n     = ST_RUN;
                    fail_code_n = FC_NONE;
                    match_cnt_n = '0;
                    cycle_cnt_n = '0;
`ifdef STORE_SEQ_CHECKER_CAPTURE_EN
                    cap_clr     = 1'b1;
`endif
                end
            end
        endcase
    end

    // Progress registers: match count, cycle count, fail cause
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_code <= FC_NONE;
            match_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            fail_code <= fail_code_n;
            match_cnt <= match_cnt_n;
            cycle_cnt <= cycle_cnt_n;
        end
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        busy = (state == ST_RUN);
        pass = (state == ST_PASS);
        fail = (state == ST_FAIL);
    end

`ifdef STORE_SEQ_CHECKER_CAPTURE_EN
    // Capture the offending store on a mismatch; cleared when a new run is armed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_addr_q <= '0;
            err_data_q <= '0;
        end else if (cap_clr) begin
            err_addr_q <= '0;
            err_data_q <= '0;
        end else if (cap_set) begin
            err_addr_q <= addr;
            err_data_q <= wdata;
        end
    end

    assign err_addr = err_addr_q;
    assign err_data = err_data_q;
`else
    assign err_addr = '0;
    assign err_data = '0;
`endif

endmodule

// File: tb/tb_store_seq_checker.sv
// tb/tb_store_seq_checker.sv - directed self-checking bench for store_seq_checker
`timescale 1ns/1ps
module tb_store_seq_checker;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;
    localparam int IDX_W   = 1;
    localparam int CNT_W   = 5;

`ifdef STORE_SEQ_CHECKER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic              w_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_code;
    logic [IDX_W:0]    match_cnt;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;

    int n_chk;
    int n_fail;

    store_seq_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tbl_we   (tbl_we),
        .tbl_idx  (tbl_idx),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .w_en     (w_en),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .pass     (pass),
        .fail     (fail),
        .fail_code(fail_code),
        .match_cnt(match_cnt),
        .cycle_cnt(cycle_cnt),
        .err_addr (err_addr),
        .err_data (err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic write_tbl(input logic [IDX_W-1:0] i, input logic [7:0] a, input logic [7:0] d);
        tbl_we = 1'b1; tbl_idx = i; tbl_addr = a; tbl_data = d;
        step(1);
        tbl_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        w_en = 1'b1; addr = a; wdata = d;
        step(1);
        w_en = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic b, input logic p, input logic f,
                              input logic [1:0] fc, input logic [IDX_W:0] mc);
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_pass"}, 32'(pass), 32'(p));
        chk({tag, "_fail"}, 32'(fail), 32'(f));
        chk({tag, "_code"}, 32'(fail_code), 32'(fc));
        chk({tag, "_match"}, 32'(match_cnt), 32'(mc));
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; start = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
        w_en = 1'b0; addr = '0; wdata = '0;
        step(2);

        chk_status("reset", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
        chk("reset_cycle", 32'(cycle_cnt), 32'd0);
        chk("reset_err_addr", 32'(err_addr), 32'd0);
        chk("reset_err_data", 32'(err_data), 32'd0);
        rst = 1'b1;
        step(1);

        write_tbl(1'b0, 8'd5, 8'd7);
        write_tbl(1'b1, 8'd6, 8'd9);

        store(8'd9, 8'd9);
        chk_status("idle_wen", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);

        // normal pass: (5,7) at cycle_cnt 3, (6,9) at cycle_cnt 6
        pulse_start();
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_cycle0", 32'(cycle_cnt), 32'd0);
        step(3);
        chk("run_cycle3", 32'(cycle_cnt), 32'd3);
        store(8'd5, 8'd7);
        chk("run_match1", 32'(match_cnt), 32'd1);
        chk("run_cycle4", 32'(cycle_cnt), 32'd4);
        step(2);
        store(8'd6, 8'd9);
        chk_status("pass", 1'b0, 1'b1, 1'b0, 2'b00, 2'd2);
        chk("pass_cycle", 32'(cycle_cnt), 32'd6);
        store(8'd1, 8'd1);
        chk_status("pass_sticky", 1'b0, 1'b1, 1'b0, 2'b00, 2'd2);
        chk("pass_sticky_cycle", 32'(cycle_cnt), 32'd6);

        // data mismatch on first entry
        pulse_start();
        chk_status("rearm", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        store(8'd5, 8'd8);
        chk_status("dmis", 1'b0, 1'b0, 1'b1, 2'b10, 2'd0);
        chk("dmis_err_addr", 32'(err_addr), CAP ? 32'd5 : 32'd0);
        chk("dmis_err_data", 32'(err_data), CAP ? 32'd8 : 32'd0);

        // address mismatch after one match
        pulse_start();
        chk("amis_cleared_err", 32'(err_addr), 32'd0);
        store(8'd5, 8'd7);
        store(8'd4, 8'd9);
        chk_status("amis", 1'b0, 1'b0, 1'b1, 2'b01, 2'd1);
        chk("amis_cycle", 32'(cycle_cnt), 32'd1);
        chk("amis_err_addr", 32'(err_addr), CAP ? 32'd4 : 32'd0);
        chk("amis_err_data", 32'(err_data), CAP ? 32'd9 : 32'd0);

        // timeout with no stores; a start pulse mid-run must not restart the count
        pulse_start();
        step(5);
        pulse_start();
        chk("to_start_ignored", 32'(cycle_cnt), 32'd6);
        step(9);
        chk_status("to_edge15", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        chk("to_cycle15", 32'(cycle_cnt), 32'd15);
        step(1);
        chk_status("timeout", 1'b0, 1'b0, 1'b1, 2'b11, 2'd0);
        chk("timeout_cycle", 32'(cycle_cnt), 32'd15);
        chk("timeout_err_addr", 32'(err_addr), 32'd0);
        chk("timeout_err_data", 32'(err_data), 32'd0);

        // last match on the timeout cycle still passes
        pulse_start();
        store(8'd5, 8'd7);
        step(14);
        chk("tpass_cycle15", 32'(cycle_cnt), 32'd15);
        store(8'd6, 8'd9);
        chk_status("tpass", 1'b0, 1'b1, 1'b0, 2'b00, 2'd2);
        chk("tpass_cycle", 32'(cycle_cnt), 32'd15);

        // start with same-cycle table write: the run sees the new entry
        start = 1'b1; tbl_we = 1'b1; tbl_idx = 1'b0; tbl_addr = 8'h15; tbl_data = 8'h17;
        step(1);
        start = 1'b0; tbl_we = 1'b0;
        store(8'h15, 8'h17);
        chk("sw_match1", 32'(match_cnt), 32'd1);
        store(8'd6, 8'd9);
        chk_status("sw_pass", 1'b0, 1'b1, 1'b0, 2'b00, 2'd2);
        write_tbl(1'b0, 8'd5, 8'd7);

        // table write during RUN is ignored
        pulse_start();
        write_tbl(1'b1, 8'hAA, 8'hBB);
        store(8'd5, 8'd7);
        store(8'd6, 8'd9);
        chk_status("runwr_pass", 1'b0, 1'b1, 1'b0, 2'b00, 2'd2);

        // asynchronous reset mid-run after one match
        pulse_start();
        store(8'd5, 8'd7);
        chk("rst_pre_match", 32'(match_cnt), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_status("async_rst", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
        chk("async_rst_cycle", 32'(cycle_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1);

        // fail then rearm cleanly to pass; table survives reset
        pulse_start();
        store(8'd6, 8'd9);
        chk_status("refail", 1'b0, 1'b0, 1'b1, 2'b01, 2'd0);
        pulse_start();
        store(8'd5, 8'd7);
        store(8'd6, 8'd9);
        chk_status("rerun_pass", 1'b0, 1'b1, 1'b0, 2'b00, 2'd2);
        chk("rerun_err_addr", 32'(err_addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
